// File: rtl/wb_slave_regbank_if.sv
// wb_slave_regbank_if: Wishbone classic signal bundle between the adapter master and the register bank
interface wb_slave_regbank_if #(
    parameter int REG_WIDTH = 32
);
    logic [4:0]             wb_adr_i;
    logic [REG_WIDTH-1:0]   wb_dat_i;
    logic [REG_WIDTH-1:0]   wb_dat_o;
    logic [REG_WIDTH/8-1:0] wb_sel_i;
    logic                   wb_we_i;
    logic                   wb_stb_i;
    logic                   wb_cyc_i;
    logic                   wb_ack_o;
    logic                   wb_err_o;
    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );
    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_slave_regbank.sv
// wb_slave_regbank: Wishbone classic slave register bank with wait states; define WB_REGBANK_ERR_EN for error termination
module wb_slave_regbank #(
    parameter int                   REG_WIDTH   = 32,
    parameter int                   NUM_REGS    = 16,
    parameter int                   WAIT_STATES = 0,
    parameter logic [REG_WIDTH-1:0] ID_VALUE    = 32'hC0DE_0001
) (
    input logic               clk,
    input logic               rst,
    wb_slave_regbank_if.slave bus
);
    localparam int AW    = $clog2(NUM_REGS);
    localparam int LANES = REG_WIDTH / 8;
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
    state_t               state;
    logic [2:0]           cnt;
    logic [4:0]           l_adr;
    logic                 l_we;
    logic [LANES-1:0]     l_sel;
    logic [REG_WIDTH-1:0] l_dat;
    logic [REG_WIDTH-1:0] regs [NUM_REGS];
    logic                 ack_q;
    logic [REG_WIDTH-1:0] dat_q;
`ifdef WB_REGBANK_ERR_EN
    logic                 err_q;
`endif
    logic                 req;
    logic                 in_idle;
    logic                 go_ack;
    logic                 hit;
    logic                 bad;
    logic [4:0]           c_adr;
    logic                 c_we;
    logic [LANES-1:0]     c_sel;
    logic [REG_WIDTH-1:0] c_dat;
    logic [AW-1:0]        idx;
    logic [REG_WIDTH-1:0] rd_val;
    // Commit uses live bus inputs when completing straight from IDLE, else the captured request
    always_comb begin
        req     = bus.wb_cyc_i & bus.wb_stb_i;
        in_idle = state == IDLE;
        c_adr   = in_idle ? bus.wb_adr_i : l_adr;
        c_we    = in_idle ? bus.wb_we_i : l_we;
        c_sel   = in_idle ? bus.wb_sel_i : l_sel;
        c_dat   = in_idle ? bus.wb_dat_i : l_dat;
        idx     = c_adr[AW-1:0];
        hit     = {1'b0, c_adr} < 6'(NUM_REGS);
        rd_val  = c_adr == 5'd0 ? ID_VALUE : hit ? regs[idx] : '0;
        go_ack  = req && (in_idle ? WAIT_STATES == 0 : state == WAIT && cnt == 3'd0);
`ifdef WB_REGBANK_ERR_EN
        bad     = !hit || (c_we && c_adr == 5'd0);
`else
        bad     = 1'b0;
`endif
    end
    // Request FSM, register file update and registered bus responses
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ack_q <= 1'b0;
            dat_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
`ifdef WB_REGBANK_ERR_EN
            err_q <= 1'b0;
`endif
        end else begin
            ack_q <= go_ack && !bad;
`ifdef WB_REGBANK_ERR_EN
            err_q <= go_ack && bad;
`endif
            if (go_ack && !bad && !c_we) dat_q <= rd_val;
            if (go_ack && !bad && c_we && hit && c_adr != 5'd0)
                for (int b = 0; b < LANES; b++)
                    if (c_sel[b]) regs[idx][8*b +: 8] <= c_dat[8*b +: 8];
            case (state)
                IDLE: if (req) begin
                    l_adr <= bus.wb_adr_i;
                    l_we  <= bus.wb_we_i;
                    l_sel <= bus.wb_sel_i;
                    l_dat <= bus.wb_dat_i;
                    cnt   <= 3'(WAIT_STATES - 1);
                    state <= WAIT_STATES > 0 ? WAIT : ACK;
                end
                WAIT: begin
                    cnt   <= cnt - 3'd1;
                    state <= !req ? IDLE : cnt == 3'd0 ? ACK : WAIT;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.wb_ack_o = ack_q;
    assign bus.wb_dat_o = dat_q;
`ifdef WB_REGBANK_ERR_EN
    assign bus.wb_err_o = err_q;
`else
    assign bus.wb_err_o = 1'b0;
`endif
endmodule
